// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the immediate generator.
//   XLEN      : datapath width
//   imm_sel_e : immediate format select encodings (3 bits)
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_U   = 3'b010,
    IMM_B   = 3'b011,
    IMM_J   = 3'b100,
    IMM_CSR = 3'b101
  } imm_sel_e;

endpackage

// File: rtl/riscv_imm_extract.sv
// Combinational immediate extraction for RV32I.
//   i_inst    : 32-bit instruction word
//   i_imm_sel : immediate format select (riscv_pkg::imm_sel_e encoding)
//   o_imm     : sign/zero-extended immediate; zero for undefined selects
module riscv_imm_extract
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_inst,
  input  logic [2:0]      i_imm_sel,
  output logic [XLEN-1:0] o_imm
);

  // Opcode bits never contribute to an immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_inst[6:0];

  always_comb begin
    o_imm = '0;
    case (imm_sel_e'(i_imm_sel))
      IMM_I:   o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S:   o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_U:   o_imm = {i_inst[31:12], 12'b0};
      IMM_B:   o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                        i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_J:   o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                        i_inst[20], i_inst[30:21], 1'b0};
      IMM_CSR: o_imm = {27'b0, i_inst[19:15]};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_imm_gen.sv
// RV32I immediate generator with optional output register.
//   clk     : system clock, rising edge (unused when OUT_REG = 0)
//   rst     : synchronous active-high reset (unused when OUT_REG = 0)
//   inst    : instruction word
//   imm_sel : immediate format select
//   out     : generated immediate (one-cycle latency when OUT_REG = 1)
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] out
);

  logic [XLEN-1:0] w_imm;

  riscv_imm_extract u_extract (
    .i_inst    (inst),
    .i_imm_sel (imm_sel),
    .o_imm     (w_imm)
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [XLEN-1:0] r_out;

      always_ff @(posedge clk) begin
        if (rst) r_out <= '0;
        else     r_out <= w_imm;
      end

      assign out = r_out;
    end else begin : g_comb
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign out = w_imm;
    end
  endgenerate

endmodule

// File: tb/tb_riscv_imm_gen.sv
module tb_riscv_imm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic [2:0]  imm_sel = '0;
  logic [31:0] out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  riscv_imm_gen #(.OUT_REG(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .imm_sel (imm_sel),
    .out     (out)
  );

  always #5 clk = ~clk;

  // Reference: immediate value computed as an integer from field weights.
  function automatic logic [31:0] ref_imm(input logic [31:0] x, input logic [2:0] s);
    int v;
    case (s)
      3'd0: v = $signed(x) >>> 20;
      3'd1: v = (($signed(x) >>> 25) * 32) + int'(x[11:7]);
      3'd2: v = int'(x & 32'hFFFF_F000);
      3'd3: v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2
                - int'(x[31]) * 4096;
      3'd4: v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2
                - int'(x[31]) * (1 << 20);
      3'd5: v = int'(x[19:15]);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Apply inputs just after an edge, then sample just after the next edge.
  task automatic apply(input logic [31:0] i, input logic [2:0] s);
    @(posedge clk); #1;
    inst = i;
    imm_sel = s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst = 32'hFFFF_FFFF;
    imm_sel = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", k, out, 32'h0);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL reset_release: got %h want %h", out, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vi [8] = '{32'hFE00_0000, 32'hFFF0_0093, 32'h7FF0_0093, 32'hFE11_2E23,
                            32'hFE00_0EE3, 32'h0080_00EF, 32'h3400_D073, 32'hFFFF_FFFF};
    logic [2:0]  vs [8] = '{3'b010, 3'b000, 3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [31:0] ve [8] = '{32'hFE00_0000, 32'hFFFF_FFFF, 32'h0000_07FF, 32'hFFFF_FFFC,
                            32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0001, 32'h0000_0000};
    for (int k = 0; k < 8; k++) begin
      apply(vi[k], vs[k]);
      n_cmp++;
      if (out !== ve[k]) begin
        n_bad++;
        $display("FAIL directed%0d inst=%h sel=%0d: got %h want %h",
                 k, vi[k], vs[k], out, ve[k]);
      end
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] r;
      logic [2:0]  s;
      r = $urandom;
      s = (k % 2 == 0) ? 3'b110 : 3'b111;
      apply(r, s);
      n_cmp++;
      if (out !== 32'h0) begin
        n_bad++;
        $display("FAIL illegal sel=%0d inst=%h: got %h want %h", s, r, out, 32'h0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [31:0] r;
      logic [2:0]  s;
      logic [31:0] e;
      r = $urandom;
      s = 3'($urandom_range(0, 7));
      e = ref_imm(r, s);
      apply(r, s);
      n_cmp++;
      if (out !== e) begin
        n_bad++;
        $display("FAIL random inst=%h sel=%0d: got %h want %h", r, s, out, e);
      end
    end
  endtask

  // New inputs every cycle; each result must emerge exactly one edge later, in order.
  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    @(posedge clk); #1;
    for (int k = 0; k < 48; k++) begin
      logic [31:0] r;
      logic [2:0]  s;
      r = $urandom;
      s = 3'(k % 8);
      inst = r;
      imm_sel = s;
      exp_q.push_back(ref_imm(r, s));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e) begin
        n_bad++;
        $display("FAIL b2b%0d sel=%0d: got %h want %h", k, s, out, e);
      end
    end
  endtask

  task automatic test_reset_dominates();
    @(posedge clk); #1;
    rst = 1'b1;
    inst = 32'h8000_0000;
    imm_sel = 3'b010;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_dominates: got %h want %h", out, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL reset_dominates_release: got %h want %h", out, 32'h8000_0000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_dominates();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
